// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the weighted round-robin arbiter.
package arb_pkg;

    localparam int N_DEF  = 4;
    localparam int WW_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority selector: first set req bit scanning ptr, ptr+1, ... modulo N.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] pos;

    // Scan from the farthest offset down so the nearest hit to ptr is written last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = IW'((int'(ptr) + k) % N);
            if (req[pos]) begin
                valid = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: an owner holds the grant for up to weight beats,
// then priority rotates past it; hand-over happens on the release edge with no bubble.
module wrr_arbiter
    import arb_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int WW = WW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*WW-1:0]      weight,
    input  logic                 xfer,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 busy
);

    localparam int IW = $clog2(N);

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_rel;
    logic [IW-1:0] sel_ptr;
    logic [WW-1:0] credit;
    logic          rel;
    logic          load;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;

    // A zero weight still grants one beat so a requester can never be starved.
    function automatic logic [WW-1:0] eff_weight(input logic [N*WW-1:0] w,
                                                 input logic [IW-1:0]   i);
        logic [WW-1:0] f;
        f = '0;
        for (int k = 0; k < N; k++) begin
            if (IW'(k) == i) f = w[k*WW +: WW];
        end
        return (f == '0) ? WW'(1) : f;
    endfunction

    rr_pick #(.N(N)) u_pick (
        .req   (req),
        .ptr   (sel_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid) state_nxt = OWN;
            OWN:     if (rel && !pick_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // During ownership the selector already looks past the owner, so a release
    // can reload the next winner on the same edge.
    always_comb begin
        ptr_rel = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
        rel     = (state == OWN) && ((xfer && (credit == WW'(1))) || !req[grant_idx]);
        sel_ptr = (state == OWN) ? ptr_rel : ptr;
        load    = pick_valid && ((state == IDLE) || rel);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant     <= '0;
            grant_idx <= '0;
            ptr       <= '0;
            credit    <= '0;
        end else begin
            if (rel) ptr <= ptr_rel;
            if (load) begin
                grant     <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
                grant_idx <= pick_idx;
                credit    <= eff_weight(weight, pick_idx);
            end else if (rel) begin
                grant     <= '0;
                grant_idx <= '0;
                credit    <= '0;
            end else if ((state == OWN) && xfer && (credit != '0)) begin
                credit    <= credit - WW'(1);
            end
        end
    end

    assign busy = |grant;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed, table-driven bench for wrr_arbiter (N=4, WW=4).
module tb_wrr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] weight;
    logic        xfer;
    logic [3:0]  grant;
    logic [1:0]  grant_idx;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    wrr_arbiter #(.N(4), .WW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .weight    (weight),
        .xfer      (xfer),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    a_grant_ok: assert property (@(negedge clk)
        $onehot0(grant) && (busy == (grant != 4'b0000)) &&
        ((grant == 4'b0000) ? (grant_idx == 2'd0) : grant[grant_idx]));

    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic [15:0] weight;
        logic        xfer;
        logic [3:0]  grant;
        logic [1:0]  idx;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] q, input logic [15:0] w,
                       input logic x, input logic [3:0] g, input logic [1:0] i,
                       input logic b);
        vec_t v;
        v.rst_n = r; v.req = q; v.weight = w; v.xfer = x;
        v.grant = g; v.idx = i; v.busy = b;
        vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic [3:0] q, input logic [15:0] w,
                        input logic x, input logic [3:0] g, input logic [1:0] i,
                        input logic b, input string name);
        rst_n = r; req = q; weight = w; xfer = x;
        @(posedge clk);
        #1;
        tests_run++;
        if (grant !== g || grant_idx !== i || busy !== b) begin
            tests_failed++;
            $display("FAIL %s: got grant=%b idx=%0d busy=%b, expected grant=%b idx=%0d busy=%b",
                     name, grant, grant_idx, busy, g, i, b);
        end
    endtask

    initial begin
        rst_n = 1'b0; req = '0; weight = '0; xfer = 1'b0;

        // Reset, then all weights 1: one beat each, no bubbles
        add(0, 4'b1111, 16'h1111, 1, 4'b0000, 0, 0);
        add(1, 4'b1111, 16'h1111, 1, 4'b0001, 0, 1);
        add(1, 4'b1111, 16'h1111, 1, 4'b0010, 1, 1);
        add(1, 4'b1111, 16'h1111, 1, 4'b0100, 2, 1);
        add(1, 4'b1111, 16'h1111, 1, 4'b1000, 3, 1);
        add(1, 4'b1111, 16'h1111, 1, 4'b0001, 0, 1);
        // Weights {3,1,2,1}
        add(0, 4'b1111, 16'h1213, 1, 4'b0000, 0, 0);
        add(1, 4'b1111, 16'h1213, 1, 4'b0001, 0, 1);
        add(1, 4'b1111, 16'h1213, 1, 4'b0001, 0, 1);
        add(1, 4'b1111, 16'h1213, 1, 4'b0001, 0, 1);
        add(1, 4'b1111, 16'h1213, 1, 4'b0010, 1, 1);
        add(1, 4'b1111, 16'h1213, 1, 4'b0100, 2, 1);
        add(1, 4'b1111, 16'h1213, 1, 4'b0100, 2, 1);
        add(1, 4'b1111, 16'h1213, 1, 4'b1000, 3, 1);
        add(1, 4'b1111, 16'h1213, 1, 4'b0001, 0, 1);
        add(1, 4'b1111, 16'h1213, 1, 4'b0001, 0, 1);
        // Sole requester with weight 0: re-granted every cycle
        add(0, 4'b0100, 16'h0000, 1, 4'b0000, 0, 0);
        add(1, 4'b0100, 16'h0000, 1, 4'b0100, 2, 1);
        add(1, 4'b0100, 16'h0000, 1, 4'b0100, 2, 1);
        add(1, 4'b0100, 16'h0000, 1, 4'b0100, 2, 1);
        // Dropping the only request returns to idle
        add(1, 4'b0000, 16'h0000, 0, 4'b0000, 0, 0);
        // xfer while idle with no requests does nothing
        add(1, 4'b0000, 16'h0000, 1, 4'b0000, 0, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].rst_n, vecs[k].req, vecs[k].weight, vecs[k].xfer,
                 vecs[k].grant, vecs[k].idx, vecs[k].busy, $sformatf("vec%0d", k));
        end

        // Owner 0 (weight 5) drops request after 2 beats; others must not preempt it
        step(0, 4'b0000, 16'h0005, 0, 4'b0000, 0, 0, "drop_rst");
        step(1, 4'b0111, 16'h0005, 0, 4'b0001, 0, 1, "drop_grant0");
        step(1, 4'b1111, 16'h0005, 1, 4'b0001, 0, 1, "drop_nopreempt1");
        step(1, 4'b0111, 16'h0005, 1, 4'b0001, 0, 1, "drop_nopreempt2");
        step(1, 4'b0110, 16'h0005, 0, 4'b0010, 1, 1, "drop_handover");
        step(1, 4'b0110, 16'h0005, 1, 4'b0100, 2, 1, "drop_ptr2");

        // Weight change during ownership must not extend the burst
        step(0, 4'b0011, 16'h0002, 0, 4'b0000, 0, 0, "wchg_rst");
        step(1, 4'b0011, 16'h0002, 0, 4'b0001, 0, 1, "wchg_grant");
        step(1, 4'b0011, 16'h000F, 1, 4'b0001, 0, 1, "wchg_beat1");
        step(1, 4'b0011, 16'h000F, 1, 4'b0010, 1, 1, "wchg_release");

        // Reset mid-burst overrides the grant; ptr restarts at 0
        step(0, 4'b0000, 16'h0000, 0, 4'b0000, 0, 0, "rst_pre");
        step(1, 4'b1000, 16'h5000, 1, 4'b1000, 3, 1, "rst_grant3");
        step(1, 4'b1000, 16'h5000, 1, 4'b1000, 3, 1, "rst_burst");
        step(0, 4'b1000, 16'h5000, 1, 4'b0000, 0, 0, "rst_mid");
        step(1, 4'b1001, 16'h5000, 0, 4'b0001, 0, 1, "rst_ptr0");

        // Idle xfer then first request granted with one-cycle latency
        step(0, 4'b0000, 16'h0000, 0, 4'b0000, 0, 0, "idle_rst");
        step(1, 4'b0000, 16'h0000, 1, 4'b0000, 0, 0, "idle_xfer");
        step(1, 4'b0010, 16'h0000, 0, 4'b0010, 1, 1, "idle_latency");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
